// File: rtl/completion_tlp_transmitter_if.sv
// Bus bundle for the completion transmitter: subunit header/payload handshakes
// on the ingress side and the 32-bit PCIe transmit stream on the egress side.
interface completion_tlp_transmitter_if;
  logic [95:0] cpl_header;
  logic [2:0]  cpl_link_source;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] in_payload;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_ready;
  logic [2:0]  tx_link_source;

  modport master (
    output cpl_header, cpl_link_source, hdr_valid, in_payload, pld_valid, tx_ready,
    input  hdr_ready, pld_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_link_source
  );

  modport slave (
    input  cpl_header, cpl_link_source, hdr_valid, in_payload, pld_valid, tx_ready,
    output hdr_ready, pld_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_link_source
  );
endinterface

// File: rtl/completion_tlp_transmitter.sv
// Serializes a 3-DW completion header plus payload onto a 32-bit registered
// transmit stream; oversize completions with data are consumed and dropped.
module completion_tlp_transmitter #(
  parameter int MAX_PAYLOAD_DW = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  completion_tlp_transmitter_if.slave bus,
  output logic                 len_err,
  output logic [CNT_WIDTH-1:0] cpl_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR1 = 3'd1,
    ST_HDR2 = 3'd2,
    ST_DATA = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD_DW);

  state_t               state_r, state_s;
  logic [63:0]          hdr_r, hdr_s;          // header DW1..DW2; DW0 goes straight out
  logic                 has_data_r, has_data_s;
  logic [10:0]          len_r, len_s;
  logic [10:0]          remaining_r, remaining_s;
  logic [2:0]           src_r, src_s;
  logic [31:0]          tx_data_r, tx_data_s;
  logic                 tx_valid_r, tx_valid_s;
  logic                 tx_sop_r, tx_sop_s;
  logic                 tx_eop_r, tx_eop_s;
  logic                 len_err_r, len_err_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;

  logic                 adv_s;
  logic                 hdr_ready_s;
  logic                 pld_ready_s;
  logic                 hdr_fire_s;
  logic                 pld_fire_s;
  logic [10:0]          hdr_len_s;
  logic                 hdr_has_data_s;

  // Handshake readiness and decode of the header currently offered.
  always_comb begin
    adv_s          = !tx_valid_r || bus.tx_ready;
    hdr_len_s      = (bus.cpl_header[9:0] == 10'd0) ? 11'd1024 : {1'b0, bus.cpl_header[9:0]};
    hdr_has_data_s = bus.cpl_header[30];
    hdr_ready_s    = 1'b0;
    pld_ready_s    = 1'b0;
    case (state_r)
      ST_IDLE: hdr_ready_s = rst_n && adv_s;
      ST_DATA: pld_ready_s = rst_n && adv_s;
      ST_DROP: pld_ready_s = rst_n;
      default: begin
        hdr_ready_s = 1'b0;
        pld_ready_s = 1'b0;
      end
    endcase
    hdr_fire_s = bus.hdr_valid && hdr_ready_s;
    pld_fire_s = bus.pld_valid && pld_ready_s;
  end

  // Next-state and next transmit word.
  always_comb begin
    state_s     = state_r;
    hdr_s       = hdr_r;
    has_data_s  = has_data_r;
    len_s       = len_r;
    remaining_s = remaining_r;
    src_s       = src_r;
    tx_data_s   = tx_data_r;
    tx_valid_s  = tx_valid_r;
    tx_sop_s    = tx_sop_r;
    tx_eop_s    = tx_eop_r;
    len_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hdr_fire_s) begin
          if (hdr_has_data_s && (hdr_len_s > MAX_LEN)) begin
            len_err_s   = 1'b1;
            remaining_s = hdr_len_s;
            tx_valid_s  = 1'b0;
            state_s     = ST_DROP;
          end else begin
            tx_data_s  = bus.cpl_header[31:0];
            tx_valid_s = 1'b1;
            tx_sop_s   = 1'b1;
            tx_eop_s   = 1'b0;
            hdr_s      = bus.cpl_header[95:32];
            has_data_s = hdr_has_data_s;
            len_s      = hdr_len_s;
            src_s      = bus.cpl_link_source;
            state_s    = ST_HDR1;
          end
        end else if (adv_s) begin
          tx_valid_s = 1'b0;
        end else begin
          tx_valid_s = tx_valid_r;
        end
      end
      ST_HDR1: begin
        if (adv_s) begin
          tx_data_s  = hdr_r[31:0];
          tx_valid_s = 1'b1;
          tx_sop_s   = 1'b0;
          tx_eop_s   = 1'b0;
          state_s    = ST_HDR2;
        end else begin
          state_s = ST_HDR1;
        end
      end
      ST_HDR2: begin
        if (adv_s) begin
          tx_data_s  = hdr_r[63:32];
          tx_valid_s = 1'b1;
          tx_sop_s   = 1'b0;
          if (has_data_r) begin
            tx_eop_s    = 1'b0;
            remaining_s = len_r;
            state_s     = ST_DATA;
          end else begin
            tx_eop_s = 1'b1;
            state_s  = ST_IDLE;
          end
        end else begin
          state_s = ST_HDR2;
        end
      end
      ST_DATA: begin
        if (pld_fire_s) begin
          tx_data_s   = bus.in_payload;
          tx_valid_s  = 1'b1;
          tx_sop_s    = 1'b0;
          tx_eop_s    = (remaining_r == 11'd1);
          remaining_s = remaining_r - 11'd1;
          state_s     = (remaining_r == 11'd1) ? ST_IDLE : ST_DATA;
        end else if (adv_s) begin
          tx_valid_s = 1'b0;
        end else begin
          tx_valid_s = tx_valid_r;
        end
      end
      ST_DROP: begin
        // The last word of the previous TLP may still be draining.
        if (adv_s) begin
          tx_valid_s = 1'b0;
        end else begin
          tx_valid_s = tx_valid_r;
        end
        if (pld_fire_s) begin
          remaining_s = remaining_r - 11'd1;
          state_s     = (remaining_r == 11'd1) ? ST_IDLE : ST_DROP;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // Completed-TLP counter advances when an eop word is accepted.
  always_comb begin
    if (tx_valid_r && bus.tx_ready && tx_eop_r) begin
      cnt_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      hdr_r       <= 64'd0;
      has_data_r  <= 1'b0;
      len_r       <= 11'd0;
      remaining_r <= 11'd0;
      src_r       <= 3'd0;
      tx_data_r   <= 32'd0;
      tx_valid_r  <= 1'b0;
      tx_sop_r    <= 1'b0;
      tx_eop_r    <= 1'b0;
      len_err_r   <= 1'b0;
      cnt_r       <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      hdr_r       <= hdr_s;
      has_data_r  <= has_data_s;
      len_r       <= len_s;
      remaining_r <= remaining_s;
      src_r       <= src_s;
      tx_data_r   <= tx_data_s;
      tx_valid_r  <= tx_valid_s;
      tx_sop_r    <= tx_sop_s;
      tx_eop_r    <= tx_eop_s;
      len_err_r   <= len_err_s;
      cnt_r       <= cnt_s;
    end
  end

  assign bus.hdr_ready      = hdr_ready_s;
  assign bus.pld_ready      = pld_ready_s;
  assign bus.tx_data        = tx_data_r;
  assign bus.tx_valid       = tx_valid_r;
  assign bus.tx_sop         = tx_sop_r;
  assign bus.tx_eop         = tx_eop_r;
  assign bus.tx_link_source = src_r;
  assign len_err            = len_err_r;
  assign cpl_count          = cnt_r;

endmodule

// File: tb/tb_completion_tlp_transmitter.sv
// Randomized scoreboard bench: completions are modelled as lists of expected
// stream words; a negedge monitor compares every accepted tx word in order.
module tb_completion_tlp_transmitter;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  src;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        len_err;
  logic [15:0] cpl_count;

  completion_tlp_transmitter_if bus();

  completion_tlp_transmitter #(.MAX_PAYLOAD_DW(256), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .len_err(len_err), .cpl_count(cpl_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  logic [31:0] pld_q[$];
  int    exp_cnt = 0;
  int    exp_len_err = 0;
  int    len_err_cnt = 0;
  int    pld_acc = 0;
  int    run = 0;
  int    max_run = 0;
  int    rmode = 0;
  bit    gap_en = 0;
  bit    pld_took = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expand one completion into expected words and payload.
  task automatic send_cpl(input bit data, input int lenf, input logic [2:0] src);
    logic [95:0] h;
    int len;
    bit drop;
    bit acc;
    logic [31:0] p;
    h = {$urandom(), $urandom(), $urandom()};
    h[31:29] = {1'b0, data, 1'b0};
    h[9:0] = 10'(lenf % 1024);
    len = ((lenf % 1024) == 0) ? 1024 : (lenf % 1024);
    drop = data && (len > 256);
    if (drop) begin
      exp_len_err++;
      for (int i = 0; i < len; i++) pld_q.push_back($urandom());
    end else begin
      exp_q.push_back('{h[31:0], 1'b1, 1'b0, src});
      exp_q.push_back('{h[63:32], 1'b0, 1'b0, src});
      exp_q.push_back('{h[95:64], 1'b0, !data, src});
      if (data) begin
        for (int i = 0; i < len; i++) begin
          p = $urandom();
          pld_q.push_back(p);
          exp_q.push_back('{p, 1'b0, (i == len - 1), src});
        end
      end
      exp_cnt++;
    end
    bus.cpl_header = h;
    bus.cpl_link_source = src;
    bus.hdr_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 5000 && !acc; c++) begin
      @(negedge clk);
      acc = bus.hdr_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("hdr_accept_timeout", 64'd0, 64'd1);
    bus.hdr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(posedge clk);
      done = (exp_q.size() == 0) && (pld_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_tx_data"}, 64'(bus.tx_data), 64'd0);
    chk({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
    chk({tag, "_tx_sop_eop"}, 64'({bus.tx_sop, bus.tx_eop}), 64'd0);
    chk({tag, "_tx_src"}, 64'(bus.tx_link_source), 64'd0);
    chk({tag, "_len_err"}, 64'(len_err), 64'd0);
    chk({tag, "_cpl_count"}, 64'(cpl_count), 64'd0);
    chk({tag, "_readies"}, 64'({bus.hdr_ready, bus.pld_ready}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    chk({tag, "_cpl_count"}, 64'(cpl_count), 64'(exp_cnt % 65536));
    chk({tag, "_len_err_pulses"}, 64'(len_err_cnt), 64'(exp_len_err));
    @(posedge clk);
    #1;
  endtask

  // tx_ready driver: always-ready, 1,0,0,1 pattern, or random.
  initial begin
    int tog;
    tog = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = ((tog % 4) == 0) || ((tog % 4) == 3);
        default: bus.tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      tog++;
    end
  end

  // Payload feeder with optional valid gaps.
  initial begin
    bus.pld_valid = 1'b0;
    bus.in_payload = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (pld_took && pld_q.size() > 0) void'(pld_q.pop_front());
      if (pld_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        bus.pld_valid = 1'b1;
        bus.in_payload = pld_q[0];
      end else begin
        bus.pld_valid = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop/compare, stall stability, len_err pulse shape.
  initial begin
    beat_t e;
    bit stall;
    bit le_prev;
    logic [33:0] prev;
    stall = 1'b0;
    le_prev = 1'b0;
    prev = 34'd0;
    forever begin
      @(negedge clk);
      pld_took = rst_n && bus.pld_valid && bus.pld_ready;
      if (rst_n) begin
        if (stall) chk("stall_hold", 64'({bus.tx_valid, bus.tx_data, bus.tx_sop, bus.tx_eop}), 64'({1'b1, prev}));
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_tx_dw", 64'(bus.tx_data), 64'hdead_beef_dead_beef);
          end else begin
            e = exp_q.pop_front();
            chk("tx_dw", 64'({bus.tx_data, bus.tx_sop, bus.tx_eop, bus.tx_link_source}), 64'(e));
          end
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        stall = bus.tx_valid && !bus.tx_ready;
        prev = {bus.tx_data, bus.tx_sop, bus.tx_eop};
        if (pld_took) pld_acc++;
        if (len_err) begin
          len_err_cnt++;
          if (le_prev) chk("len_err_width", 64'd2, 64'd1);
        end
        le_prev = len_err;
      end else begin
        stall = 1'b0;
        run = 0;
        le_prev = 1'b0;
      end
    end
  end

  initial begin
    int base;
    bit got;
    rst_n = 1'b0;
    bus.hdr_valid = 1'b0;
    bus.cpl_header = 96'd0;
    bus.cpl_link_source = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Cpl without data: three words only.
    rmode = 0;
    send_cpl(1'b0, 1, 3'd1);
    wait_drain();
    check_counts("cpl_nodata");

    // CplD with four payload words from the memory subunit.
    send_cpl(1'b1, 4, 3'd2);
    wait_drain();
    check_counts("cpld_len4");

    // Backpressure pattern plus payload bubbles.
    rmode = 1;
    gap_en = 1;
    send_cpl(1'b1, 2, 3'd3);
    send_cpl(1'b1, 5, 3'd1);
    wait_drain();
    check_counts("backpressure");

    // Oversize: 300 DW and 1024 DW (length field 0) are dropped.
    rmode = 2;
    send_cpl(1'b1, 300, 3'd2);
    send_cpl(1'b1, 0, 3'd3);
    wait_drain();
    check_counts("oversize");

    // Back-to-back Cpl headers with tx always ready.
    rmode = 0;
    gap_en = 0;
    max_run = 0;
    send_cpl(1'b0, 7, 3'd1);
    send_cpl(1'b0, 9, 3'd2);
    wait_drain();
    chk("b2b_run", 64'(max_run), 64'd6);
    check_counts("b2b");

    // Randomized mix; also covers the 256 DW boundary.
    rmode = 2;
    gap_en = 1;
    send_cpl(1'b1, 256, 3'd1);
    send_cpl(1'b1, 257, 3'd2);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) send_cpl(1'b0, $urandom_range(0, 1023), 3'($urandom_range(1, 3)));
      else if ($urandom_range(0, 7) == 0) send_cpl(1'b1, $urandom_range(257, 320), 3'($urandom_range(1, 3)));
      else send_cpl(1'b1, $urandom_range(1, 12), 3'($urandom_range(1, 3)));
    end
    wait_drain();
    check_counts("random");

    // Reset in the middle of payload after two of eight words.
    rmode = 0;
    gap_en = 0;
    base = pld_acc;
    send_cpl(1'b1, 8, 3'd2);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk);
      got = (pld_acc >= base + 2);
    end
    if (!got) chk("mid_reset_wait_timeout", 64'd0, 64'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    pld_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    check_idle_outputs("mid_reset");
    rst_n = 1'b1;
    send_cpl(1'b1, 3, 3'd3);
    wait_drain();
    check_counts("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/completion_tlp_transmitter.md
Name: completion_tlp_transmitter

Overview:
Egress-side counterpart of the ingress header sorter. It accepts a 96-bit completion header and its payload from a hardware subunit (config, memory or I/O), then serializes them as a 3-DW header followed by payload DWs onto a 32-bit PCIe transmit stream with valid/ready flow control. It decides with/without data from the fmt field, counts payload DWs from the length field, and drops oversize completions.

Parameters:
MAX_PAYLOAD_DW, 256, largest payload in DW that may be transmitted; longer completions are dropped.
CNT_WIDTH, 16, width of the transmitted-completion counter.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
cpl_header  input  96  completion header from subunit (same bit layout the sorter produces).
cpl_link_source  input  3  subunit ID (1 config, 2 memory, 3 I/O); latched with header.
hdr_valid  input  1  cpl_header/cpl_link_source valid.
hdr_ready  output  1  header accepted when hdr_valid && hdr_ready.
in_payload  input  32  payload DW from subunit.
pld_valid  input  1  in_payload valid.
pld_ready  output  1  payload DW consumed when pld_valid && pld_ready.
tx_data  output  32  DW to PCIe physical layer.
tx_valid  output  1  tx_data valid.
tx_sop  output  1  marks DW0 of a TLP.
tx_eop  output  1  marks last DW of a TLP.
tx_ready  input  1  physical layer accepts DW when tx_valid && tx_ready.
tx_link_source  output  3  latched cpl_link_source of TLP in flight.
len_err  output  1  one-cycle pulse: completion dropped for length.
cpl_count  output  CNT_WIDTH  number of TLPs fully transmitted (eop accepted), wraps.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; tx_data, tx_valid, tx_sop, tx_eop, tx_link_source, len_err, cpl_count = 0. Partial TLP in flight is abandoned, no eop emitted. hdr_ready/pld_ready are 0 while rst_n=0.
- Output register: tx_* registered. "adv" = !tx_valid || tx_ready. tx_data/sop/eop must hold stable while tx_valid && !tx_ready.
- Length decode: len = cpl_header[9:0]; len==0 means 1024 DW. has_data = cpl_header[30] (fmt 010 = CplD; fmt 000 = Cpl, no data).
- States: IDLE, HDR1, HDR2, DATA, DROP.
- IDLE: hdr_ready = adv. On accept: if has_data && len > MAX_PAYLOAD_DW -> pulse len_err next cycle, go DROP with remaining=len, nothing transmitted. Else load DW0 = cpl_header[31:0], tx_sop=1, tx_eop=0, tx_valid=1; latch header and source; go HDR1. Latency: header accepted cycle N -> DW0 on tx at N+1.
- HDR1 (on adv): drive DW1 = header[63:32], sop=0 -> HDR2.
- HDR2 (on adv): drive DW2 = header[95:64]; eop=1 if !has_data -> IDLE; else eop=0, remaining=len -> DATA.
- DATA: pld_ready = adv. Each accepted payload DW drives tx_data=in_payload, tx_valid=1; remaining decrements; eop=1 on the DW where remaining==1, then -> IDLE. If adv && !pld_valid, tx_valid drops to 0 (bubble allowed, no sop/eop change).
- DROP: pld_ready=1 unconditionally; consume remaining DWs without tx activity; -> IDLE after last. tx side may still drain previous word.
- Whenever tx accept occurs with tx_eop=1, cpl_count increments (wraps at 2^CNT_WIDTH).
- Back-to-back: in IDLE, a new header may be accepted in the same cycle the previous eop DW is accepted; DW0 of the next TLP follows with no bubble.
- hdr_ready=0 in every state except IDLE; payload presented outside DATA/DROP is not consumed.
- tx_link_source updates only on header accept.
- Counter remaining is 11 bits to hold 1024.

Test Plan:
- Cpl no data: header fmt=000, len=1, tx_ready=1 -> exactly 3 DWs, sop on DW0, eop on DW2, cpl_count 0->1, pld_ready never asserted.
- CplD len=4: fmt=010, payload A0..A3 -> 7 DWs: hdr[31:0], hdr[63:32], hdr[95:64], A0..A3; eop only on A3; tx_link_source=2.
- Backpressure: CplD len=2, tx_ready toggles 1,0,0,1,... -> tx_data/sop/eop stable in all stalled cycles; no DW lost or duplicated; pld_valid gaps produce tx_valid=0 bubbles only.
- Oversize: MAX_PAYLOAD_DW=256, fmt=010, len=300 -> len_err one-cycle pulse, 300 payload DWs consumed, tx_valid stays 0, cpl_count unchanged; len=0 (1024) also dropped.
- Back-to-back: two Cpl headers with hdr_valid held, tx_ready=1 -> 6 consecutive valid DWs, second sop immediately after first eop, cpl_count=2.
- Reset mid-TLP: assert rst_n=0 during DATA after 2 of 8 payload DWs -> next cycle all outputs 0, state IDLE, new header after reset transmits cleanly.
